lsu_dport: RTL

- Load/store initiator for the core's data-SRAM port (dat_a/dat_we/dat_wd/dat_re/dat_rd). It is the requester side of the byte-lane data-memory protocol.
- Accepts one RV32I load or store per cycle from the execute stage.
- Converts each request into byte-lane enables and lane-replicated write data.
- Captures the memory's one-cycle-latency read data, then aligns and sign/zero-extends it into a registered writeback result.
- Flags misaligned and illegal accesses instead of issuing them.

---
 rtl/lsu_dport_if.sv | 47 ++++
 rtl/lsu_dport.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_dport_if.sv
// lsu_dport_if: bundle of request, data-SRAM and writeback signals for the
// load/store data port.
//   req_*   : one load/store request per cycle from execute
//   flush   : kill the load sitting in stage 1
//   dat_*   : byte-lane data-SRAM port (read data arrives one cycle after dat_re)
//   ld_*    : registered load writeback
//   exc_*   : registered one-cycle exception report
// slave  = lsu_dport side, master = core/SRAM side.
interface lsu_dport_if #(
  parameter int ADDR_W = 16
);
  logic              req_vld;
  logic              req_ld;
  logic              req_st;
  logic [2:0]        req_f3;
  logic [31:0]       req_a;
  logic [31:0]       req_wd;
  logic [4:0]        req_rd_a;
  logic              flush;

  logic [ADDR_W-1:0] dat_a;
  logic [3:0]        dat_we;
  logic [31:0]       dat_wd;
  logic [3:0]        dat_re;
  logic [31:0]       dat_rd;

  logic              ld_vld;
  logic [4:0]        ld_rd_a;
  logic [31:0]       ld_data;
  logic              exc_vld;
  logic [3:0]        exc_code;
  logic [31:0]       exc_a;

  modport slave (
    input  req_vld, req_ld, req_st, req_f3, req_a, req_wd, req_rd_a, flush,
    input  dat_rd,
    output dat_a, dat_we, dat_wd, dat_re,
    output ld_vld, ld_rd_a, ld_data, exc_vld, exc_code, exc_a
  );

  modport master (
    output req_vld, req_ld, req_st, req_f3, req_a, req_wd, req_rd_a, flush,
    output dat_rd,
    input  dat_a, dat_we, dat_wd, dat_re,
    input  ld_vld, ld_rd_a, ld_data, exc_vld, exc_code, exc_a
  );
endinterface

// File: rtl/lsu_dport.sv
// lsu_dport: RV32I load/store initiator for the data-SRAM port.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : lsu_dport_if.slave (request in, SRAM drive out, writeback/exception out)
// Cycle N  : request decoded; legal accesses drive dat_* combinationally,
//            illegal/misaligned ones drive nothing and raise exc_* in N+1.
// Cycle N+1: SRAM read data aligned and extended.
// Cycle N+2: ld_vld/ld_data visible (2-cycle load latency, no back-pressure).

// One byte lane of the SRAM drive: enable gating and store-data replication.
module lsu_dport_lane #(
  parameter int LANE = 0
) (
  input  logic        en_i,   // lane selected by size/offset
  input  logic        st_i,   // legal store issuing this cycle
  input  logic        ld_i,   // legal load issuing this cycle
  input  logic [1:0]  sz_i,   // 0 byte, 1 half, 2 word
  input  logic [31:0] wd_i,   // right-justified store data
  output logic        we_o,
  output logic        re_o,
  output logic [7:0]  wd_o
);
  always_comb begin
    we_o = st_i & en_i;
    re_o = ld_i & en_i;
    wd_o = '0;
    if (st_i) begin
      // Replicate the datum so every lane that could be enabled holds it;
      // the byte enables decide which lanes actually land.
      unique case (sz_i)
        2'd0:    wd_o = wd_i[7:0];
        2'd1:    wd_o = wd_i[(LANE % 2) * 8 +: 8];
        default: wd_o = wd_i[LANE * 8 +: 8];
      endcase
    end
  end
endmodule

module lsu_dport #(
  parameter int ADDR_W     = 16,
  parameter int EXC_LD_MIS = 4,
  parameter int EXC_ST_MIS = 6,
  parameter int EXC_ILL    = 2
) (
  input logic      clk,
  input logic      rstn,
  lsu_dport_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int STAGES    = 2;

  // ---------------- request decode (cycle N) ----------------
  logic [1:0] off;
  logic [1:0] sz;
  logic       is_ld, is_st, both;
  logic       f3_ok_ld, f3_ok_st;
  logic       ill, mis, go, ld_go, st_go;
  logic [NUM_LANES-1:0] lane_en;

  assign off  = bus.req_a[1:0];
  assign sz   = bus.req_f3[1:0];
  assign both = bus.req_ld & bus.req_st;
  assign is_ld = bus.req_ld & ~bus.req_st;
  assign is_st = bus.req_st & ~bus.req_ld;

  always_comb begin
    f3_ok_ld = 1'b0;
    f3_ok_st = 1'b0;
    unique case (bus.req_f3)
      3'b000, 3'b001, 3'b010: begin f3_ok_ld = 1'b1; f3_ok_st = 1'b1; end
      3'b100, 3'b101:         f3_ok_ld = 1'b1;
      default: ;
    endcase
  end

  // Illegal dominates misaligned, so misalignment is only evaluated for
  // requests whose f3 is already known good.
  assign ill = bus.req_vld & (both | (is_ld & ~f3_ok_ld) | (is_st & ~f3_ok_st));
  assign mis = bus.req_vld & (is_ld | is_st) & ~ill &
               (((sz == 2'd1) & off[0]) | ((sz == 2'd2) & (off != 2'd0)));
  assign go    = bus.req_vld & (is_ld | is_st) & ~ill & ~mis;
  assign ld_go = go & is_ld;
  assign st_go = go & is_st;

  always_comb begin
    unique case (sz)
      2'd0:    lane_en = 4'b0001 << off;
      2'd1:    lane_en = 4'b0011 << off;
      default: lane_en = 4'b1111;
    endcase
  end

  // ---------------- SRAM drive ----------------
  logic [NUM_LANES-1:0]      we_lane, re_lane;
  logic [NUM_LANES-1:0][7:0] wd_lane;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_dport_lane #(.LANE(i)) u_lane (
      .en_i (lane_en[i]),
      .st_i (st_go),
      .ld_i (ld_go),
      .sz_i (sz),
      .wd_i (bus.req_wd),
      .we_o (we_lane[i]),
      .re_o (re_lane[i]),
      .wd_o (wd_lane[i])
    );
  end

  assign bus.dat_we = we_lane;
  assign bus.dat_re = re_lane;
  assign bus.dat_wd = wd_lane;
  assign bus.dat_a  = go ? bus.req_a[ADDR_W-1:0] : '0;

  // Address bits above ADDR_W are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.req_a[31:ADDR_W]};

  // ---------------- exception register ----------------
  logic       exc_vld_q;
  logic [3:0] exc_code_q, exc_code_d;
  logic [31:0] exc_a_q;

  always_comb begin
    exc_code_d = 4'(EXC_ILL);
    if (!ill) exc_code_d = is_ld ? 4'(EXC_LD_MIS) : 4'(EXC_ST_MIS);
  end

  // ---------------- load pipeline ----------------
  // vld_pipe_q[1] = load in stage 1 (SRAM read in flight), [2] = ld_vld.
  logic [STAGES:1] vld_pipe_q;
  logic [2:0]      s1_f3_q;
  logic [1:0]      s1_off_q;
  logic [4:0]      s1_rd_q;
  logic            s1_done;
  logic [31:0]     rd_sh;
  logic [31:0]     ld_data_d, ld_data_q;
  logic [4:0]      ld_rd_q;

  // A flush kills only the load already in stage 1; a new request in the
  // flush cycle still enters stage 1 normally.
  assign s1_done = vld_pipe_q[1] & ~bus.flush;

  // Bring the addressed byte/half down to bit 0; lanes above it are stale.
  assign rd_sh = bus.dat_rd >> {s1_off_q, 3'b000};

  always_comb begin
    unique case (s1_f3_q)
      3'b000:  ld_data_d = {{24{rd_sh[7]}},  rd_sh[7:0]};
      3'b001:  ld_data_d = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_data_d = {24'd0, rd_sh[7:0]};
      3'b101:  ld_data_d = {16'd0, rd_sh[15:0]};
      default: ld_data_d = rd_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      s1_f3_q    <= '0;
      s1_off_q   <= '0;
      s1_rd_q    <= '0;
      ld_data_q  <= '0;
      ld_rd_q    <= '0;
      exc_vld_q  <= 1'b0;
      exc_code_q <= '0;
      exc_a_q    <= '0;
    end else begin
      vld_pipe_q <= {s1_done, ld_go};
      if (ld_go) begin
        s1_f3_q  <= bus.req_f3;
        s1_off_q <= off;
        s1_rd_q  <= bus.req_rd_a;
      end
      // Writeback holds its last value between results.
      if (s1_done) begin
        ld_data_q <= ld_data_d;
        ld_rd_q   <= s1_rd_q;
      end
      exc_vld_q <= ill | mis;
      if (ill | mis) begin
        exc_code_q <= exc_code_d;
        exc_a_q    <= bus.req_a;
      end
    end
  end

  assign bus.ld_vld   = vld_pipe_q[STAGES];
  assign bus.ld_rd_a  = ld_rd_q;
  assign bus.ld_data  = ld_data_q;
  assign bus.exc_vld  = exc_vld_q;
  assign bus.exc_code = exc_code_q;
  assign bus.exc_a    = exc_a_q;
endmodule
